inv_sub_bytes_seq: RTL and testbench

//  Sequential AES InvSubBytes for the decryption datapath: accepts a 128-bit state,

---
 rtl/inv_sub_bytes_seq.sv | 181 ++++++++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: LANES inverse S-boxes sweep the 16 state bytes over 16/LANES cycles.
// Optional INV_SUB_BYTES_CHECK_EN re-encrypts each lane result through a forward S-box and flags mismatches on err_o.

module inv_sub_bytes_lane (
  input  logic [7:0] din_i,
  output logic [7:0] dout_o
`ifdef INV_SUB_BYTES_CHECK_EN
  ,output logic      mism_o
`endif
);
  logic [7:0] y;
  always_comb begin
    y = 8'h00;
    case (din_i)
      8'h00: y = 8'h52; 8'h01: y = 8'h09; 8'h02: y = 8'h6a; 8'h03: y = 8'hd5; 8'h04: y = 8'h30; 8'h05: y = 8'h36; 8'h06: y = 8'ha5; 8'h07: y = 8'h38; 8'h08: y = 8'hbf; 8'h09: y = 8'h40; 8'h0a: y = 8'ha3; 8'h0b: y = 8'h9e; 8'h0c: y = 8'h81; 8'h0d: y = 8'hf3; 8'h0e: y = 8'hd7; 8'h0f: y = 8'hfb;
      8'h10: y = 8'h7c; 8'h11: y = 8'he3; 8'h12: y = 8'h39; 8'h13: y = 8'h82; 8'h14: y = 8'h9b; 8'h15: y = 8'h2f; 8'h16: y = 8'hff; 8'h17: y = 8'h87; 8'h18: y = 8'h34; 8'h19: y = 8'h8e; 8'h1a: y = 8'h43; 8'h1b: y = 8'h44; 8'h1c: y = 8'hc4; 8'h1d: y = 8'hde; 8'h1e: y = 8'he9; 8'h1f: y = 8'hcb;
      8'h20: y = 8'h54; 8'h21: y = 8'h7b; 8'h22: y = 8'h94; 8'h23: y = 8'h32; 8'h24: y = 8'ha6; 8'h25: y = 8'hc2; 8'h26: y = 8'h23; 8'h27: y = 8'h3d; 8'h28: y = 8'hee; 8'h29: y = 8'h4c; 8'h2a: y = 8'h95; 8'h2b: y = 8'h0b; 8'h2c: y = 8'h42; 8'h2d: y = 8'hfa; 8'h2e: y = 8'hc3; 8'h2f: y = 8'h4e;
      8'h30: y = 8'h08; 8'h31: y = 8'h2e; 8'h32: y = 8'ha1; 8'h33: y = 8'h66; 8'h34: y = 8'h28; 8'h35: y = 8'hd9; 8'h36: y = 8'h24; 8'h37: y = 8'hb2; 8'h38: y = 8'h76; 8'h39: y = 8'h5b; 8'h3a: y = 8'ha2; 8'h3b: y = 8'h49; 8'h3c: y = 8'h6d; 8'h3d: y = 8'h8b; 8'h3e: y = 8'hd1; 8'h3f: y = 8'h25;
      8'h40: y = 8'h72; 8'h41: y = 8'hf8; 8'h42: y = 8'hf6; 8'h43: y = 8'h64; 8'h44: y = 8'h86; 8'h45: y = 8'h68; 8'h46: y = 8'h98; 8'h47: y = 8'h16; 8'h48: y = 8'hd4; 8'h49: y = 8'ha4; 8'h4a: y = 8'h5c; 8'h4b: y = 8'hcc; 8'h4c: y = 8'h5d; 8'h4d: y = 8'h65; 8'h4e: y = 8'hb6; 8'h4f: y = 8'h92;
      8'h50: y = 8'h6c; 8'h51: y = 8'h70; 8'h52: y = 8'h48; 8'h53: y = 8'h50; 8'h54: y = 8'hfd; 8'h55: y = 8'hed; 8'h56: y = 8'hb9; 8'h57: y = 8'hda; 8'h58: y = 8'h5e; 8'h59: y = 8'h15; 8'h5a: y = 8'h46; 8'h5b: y = 8'h57; 8'h5c: y = 8'ha7; 8'h5d: y = 8'h8d; 8'h5e: y = 8'h9d; 8'h5f: y = 8'h84;
      8'h60: y = 8'h90; 8'h61: y = 8'hd8; 8'h62: y = 8'hab; 8'h63: y = 8'h00; 8'h64: y = 8'h8c; 8'h65: y = 8'hbc; 8'h66: y = 8'hd3; 8'h67: y = 8'h0a; 8'h68: y = 8'hf7; 8'h69: y = 8'he4; 8'h6a: y = 8'h58; 8'h6b: y = 8'h05; 8'h6c: y = 8'hb8; 8'h6d: y = 8'hb3; 8'h6e: y = 8'h45; 8'h6f: y = 8'h06;
      8'h70: y = 8'hd0; 8'h71: y = 8'h2c; 8'h72: y = 8'h1e; 8'h73: y = 8'h8f; 8'h74: y = 8'hca; 8'h75: y = 8'h3f; 8'h76: y = 8'h0f; 8'h77: y = 8'h02; 8'h78: y = 8'hc1; 8'h79: y = 8'haf; 8'h7a: y = 8'hbd; 8'h7b: y = 8'h03; 8'h7c: y = 8'h01; 8'h7d: y = 8'h13; 8'h7e: y = 8'h8a; 8'h7f: y = 8'h6b;
      8'h80: y = 8'h3a; 8'h81: y = 8'h91; 8'h82: y = 8'h11; 8'h83: y = 8'h41; 8'h84: y = 8'h4f; 8'h85: y = 8'h67; 8'h86: y = 8'hdc; 8'h87: y = 8'hea; 8'h88: y = 8'h97; 8'h89: y = 8'hf2; 8'h8a: y = 8'hcf; 8'h8b: y = 8'hce; 8'h8c: y = 8'hf0; 8'h8d: y = 8'hb4; 8'h8e: y = 8'he6; 8'h8f: y = 8'h73;
      8'h90: y = 8'h96; 8'h91: y = 8'hac; 8'h92: y = 8'h74; 8'h93: y = 8'h22; 8'h94: y = 8'he7; 8'h95: y = 8'had; 8'h96: y = 8'h35; 8'h97: y = 8'h85; 8'h98: y = 8'he2; 8'h99: y = 8'hf9; 8'h9a: y = 8'h37; 8'h9b: y = 8'he8; 8'h9c: y = 8'h1c; 8'h9d: y = 8'h75; 8'h9e: y = 8'hdf; 8'h9f: y = 8'h6e;
      8'ha0: y = 8'h47; 8'ha1: y = 8'hf1; 8'ha2: y = 8'h1a; 8'ha3: y = 8'h71; 8'ha4: y = 8'h1d; 8'ha5: y = 8'h29; 8'ha6: y = 8'hc5; 8'ha7: y = 8'h89; 8'ha8: y = 8'h6f; 8'ha9: y = 8'hb7; 8'haa: y = 8'h62; 8'hab: y = 8'h0e; 8'hac: y = 8'haa; 8'had: y = 8'h18; 8'hae: y = 8'hbe; 8'haf: y = 8'h1b;
      8'hb0: y = 8'hfc; 8'hb1: y = 8'h56; 8'hb2: y = 8'h3e; 8'hb3: y = 8'h4b; 8'hb4: y = 8'hc6; 8'hb5: y = 8'hd2; 8'hb6: y = 8'h79; 8'hb7: y = 8'h20; 8'hb8: y = 8'h9a; 8'hb9: y = 8'hdb; 8'hba: y = 8'hc0; 8'hbb: y = 8'hfe; 8'hbc: y = 8'h78; 8'hbd: y = 8'hcd; 8'hbe: y = 8'h5a; 8'hbf: y = 8'hf4;
      8'hc0: y = 8'h1f; 8'hc1: y = 8'hdd; 8'hc2: y = 8'ha8; 8'hc3: y = 8'h33; 8'hc4: y = 8'h88; 8'hc5: y = 8'h07; 8'hc6: y = 8'hc7; 8'hc7: y = 8'h31; 8'hc8: y = 8'hb1; 8'hc9: y = 8'h12; 8'hca: y = 8'h10; 8'hcb: y = 8'h59; 8'hcc: y = 8'h27; 8'hcd: y = 8'h80; 8'hce: y = 8'hec; 8'hcf: y = 8'h5f;
      8'hd0: y = 8'h60; 8'hd1: y = 8'h51; 8'hd2: y = 8'h7f; 8'hd3: y = 8'ha9; 8'hd4: y = 8'h19; 8'hd5: y = 8'hb5; 8'hd6: y = 8'h4a; 8'hd7: y = 8'h0d; 8'hd8: y = 8'h2d; 8'hd9: y = 8'he5; 8'hda: y = 8'h7a; 8'hdb: y = 8'h9f; 8'hdc: y = 8'h93; 8'hdd: y = 8'hc9; 8'hde: y = 8'h9c; 8'hdf: y = 8'hef;
      8'he0: y = 8'ha0; 8'he1: y = 8'he0; 8'he2: y = 8'h3b; 8'he3: y = 8'h4d; 8'he4: y = 8'hae; 8'he5: y = 8'h2a; 8'he6: y = 8'hf5; 8'he7: y = 8'hb0; 8'he8: y = 8'hc8; 8'he9: y = 8'heb; 8'hea: y = 8'hbb; 8'heb: y = 8'h3c; 8'hec: y = 8'h83; 8'hed: y = 8'h53; 8'hee: y = 8'h99; 8'hef: y = 8'h61;
      8'hf0: y = 8'h17; 8'hf1: y = 8'h2b; 8'hf2: y = 8'h04; 8'hf3: y = 8'h7e; 8'hf4: y = 8'hba; 8'hf5: y = 8'h77; 8'hf6: y = 8'hd6; 8'hf7: y = 8'h26; 8'hf8: y = 8'he1; 8'hf9: y = 8'h69; 8'hfa: y = 8'h14; 8'hfb: y = 8'h63; 8'hfc: y = 8'h55; 8'hfd: y = 8'h21; 8'hfe: y = 8'h0c; 8'hff: y = 8'h7d;
      default: y = 8'h00;
    endcase
  end
  assign dout_o = y;

`ifdef INV_SUB_BYTES_CHECK_EN
  // Forward S-box: a correct lane maps its result back to the original byte.
  logic [7:0] f;
  always_comb begin
    f = 8'h00;
    case (dout_o)
      8'h00: f = 8'h63; 8'h01: f = 8'h7c; 8'h02: f = 8'h77; 8'h03: f = 8'h7b; 8'h04: f = 8'hf2; 8'h05: f = 8'h6b; 8'h06: f = 8'h6f; 8'h07: f = 8'hc5; 8'h08: f = 8'h30; 8'h09: f = 8'h01; 8'h0a: f = 8'h67; 8'h0b: f = 8'h2b; 8'h0c: f = 8'hfe; 8'h0d: f = 8'hd7; 8'h0e: f = 8'hab; 8'h0f: f = 8'h76;
      8'h10: f = 8'hca; 8'h11: f = 8'h82; 8'h12: f = 8'hc9; 8'h13: f = 8'h7d; 8'h14: f = 8'hfa; 8'h15: f = 8'h59; 8'h16: f = 8'h47; 8'h17: f = 8'hf0; 8'h18: f = 8'had; 8'h19: f = 8'hd4; 8'h1a: f = 8'ha2; 8'h1b: f = 8'haf; 8'h1c: f = 8'h9c; 8'h1d: f = 8'ha4; 8'h1e: f = 8'h72; 8'h1f: f = 8'hc0;
      8'h20: f = 8'hb7; 8'h21: f = 8'hfd; 8'h22: f = 8'h93; 8'h23: f = 8'h26; 8'h24: f = 8'h36; 8'h25: f = 8'h3f; 8'h26: f = 8'hf7; 8'h27: f = 8'hcc; 8'h28: f = 8'h34; 8'h29: f = 8'ha5; 8'h2a: f = 8'he5; 8'h2b: f = 8'hf1; 8'h2c: f = 8'h71; 8'h2d: f = 8'hd8; 8'h2e: f = 8'h31; 8'h2f: f = 8'h15;
      8'h30: f = 8'h04; 8'h31: f = 8'hc7; 8'h32: f = 8'h23; 8'h33: f = 8'hc3; 8'h34: f = 8'h18; 8'h35: f = 8'h96; 8'h36: f = 8'h05; 8'h37: f = 8'h9a; 8'h38: f = 8'h07; 8'h39: f = 8'h12; 8'h3a: f = 8'h80; 8'h3b: f = 8'he2; 8'h3c: f = 8'heb; 8'h3d: f = 8'h27; 8'h3e: f = 8'hb2; 8'h3f: f = 8'h75;
      8'h40: f = 8'h09; 8'h41: f = 8'h83; 8'h42: f = 8'h2c; 8'h43: f = 8'h1a; 8'h44: f = 8'h1b; 8'h45: f = 8'h6e; 8'h46: f = 8'h5a; 8'h47: f = 8'ha0; 8'h48: f = 8'h52; 8'h49: f = 8'h3b; 8'h4a: f = 8'hd6; 8'h4b: f = 8'hb3; 8'h4c: f = 8'h29; 8'h4d: f = 8'he3; 8'h4e: f = 8'h2f; 8'h4f: f = 8'h84;
      8'h50: f = 8'h53; 8'h51: f = 8'hd1; 8'h52: f = 8'h00; 8'h53: f = 8'hed; 8'h54: f = 8'h20; 8'h55: f = 8'hfc; 8'h56: f = 8'hb1; 8'h57: f = 8'h5b; 8'h58: f = 8'h6a; 8'h59: f = 8'hcb; 8'h5a: f = 8'hbe; 8'h5b: f = 8'h39; 8'h5c: f = 8'h4a; 8'h5d: f = 8'h4c; 8'h5e: f = 8'h58; 8'h5f: f = 8'hcf;
      8'h60: f = 8'hd0; 8'h61: f = 8'hef; 8'h62: f = 8'haa; 8'h63: f = 8'hfb; 8'h64: f = 8'h43; 8'h65: f = 8'h4d; 8'h66: f = 8'h33; 8'h67: f = 8'h85; 8'h68: f = 8'h45; 8'h69: f = 8'hf9; 8'h6a: f = 8'h02; 8'h6b: f = 8'h7f; 8'h6c: f = 8'h50; 8'h6d: f = 8'h3c; 8'h6e: f = 8'h9f; 8'h6f: f = 8'ha8;
      8'h70: f = 8'h51; 8'h71: f = 8'ha3; 8'h72: f = 8'h40; 8'h73: f = 8'h8f; 8'h74: f = 8'h92; 8'h75: f = 8'h9d; 8'h76: f = 8'h38; 8'h77: f = 8'hf5; 8'h78: f = 8'hbc; 8'h79: f = 8'hb6; 8'h7a: f = 8'hda; 8'h7b: f = 8'h21; 8'h7c: f = 8'h10; 8'h7d: f = 8'hff; 8'h7e: f = 8'hf3; 8'h7f: f = 8'hd2;
      8'h80: f = 8'hcd; 8'h81: f = 8'h0c; 8'h82: f = 8'h13; 8'h83: f = 8'hec; 8'h84: f = 8'h5f; 8'h85: f = 8'h97; 8'h86: f = 8'h44; 8'h87: f = 8'h17; 8'h88: f = 8'hc4; 8'h89: f = 8'ha7; 8'h8a: f = 8'h7e; 8'h8b: f = 8'h3d; 8'h8c: f = 8'h64; 8'h8d: f = 8'h5d; 8'h8e: f = 8'h19; 8'h8f: f = 8'h73;
      8'h90: f = 8'h60; 8'h91: f = 8'h81; 8'h92: f = 8'h4f; 8'h93: f = 8'hdc; 8'h94: f = 8'h22; 8'h95: f = 8'h2a; 8'h96: f = 8'h90; 8'h97: f = 8'h88; 8'h98: f = 8'h46; 8'h99: f = 8'hee; 8'h9a: f = 8'hb8; 8'h9b: f = 8'h14; 8'h9c: f = 8'hde; 8'h9d: f = 8'h5e; 8'h9e: f = 8'h0b; 8'h9f: f = 8'hdb;
      8'ha0: f = 8'he0; 8'ha1: f = 8'h32; 8'ha2: f = 8'h3a; 8'ha3: f = 8'h0a; 8'ha4: f = 8'h49; 8'ha5: f = 8'h06; 8'ha6: f = 8'h24; 8'ha7: f = 8'h5c; 8'ha8: f = 8'hc2; 8'ha9: f = 8'hd3; 8'haa: f = 8'hac; 8'hab: f = 8'h62; 8'hac: f = 8'h91; 8'had: f = 8'h95; 8'hae: f = 8'he4; 8'haf: f = 8'h79;
      8'hb0: f = 8'he7; 8'hb1: f = 8'hc8; 8'hb2: f = 8'h37; 8'hb3: f = 8'h6d; 8'hb4: f = 8'h8d; 8'hb5: f = 8'hd5; 8'hb6: f = 8'h4e; 8'hb7: f = 8'ha9; 8'hb8: f = 8'h6c; 8'hb9: f = 8'h56; 8'hba: f = 8'hf4; 8'hbb: f = 8'hea; 8'hbc: f = 8'h65; 8'hbd: f = 8'h7a; 8'hbe: f = 8'hae; 8'hbf: f = 8'h08;
      8'hc0: f = 8'hba; 8'hc1: f = 8'h78; 8'hc2: f = 8'h25; 8'hc3: f = 8'h2e; 8'hc4: f = 8'h1c; 8'hc5: f = 8'ha6; 8'hc6: f = 8'hb4; 8'hc7: f = 8'hc6; 8'hc8: f = 8'he8; 8'hc9: f = 8'hdd; 8'hca: f = 8'h74; 8'hcb: f = 8'h1f; 8'hcc: f = 8'h4b; 8'hcd: f = 8'hbd; 8'hce: f = 8'h8b; 8'hcf: f = 8'h8a;
      8'hd0: f = 8'h70; 8'hd1: f = 8'h3e; 8'hd2: f = 8'hb5; 8'hd3: f = 8'h66; 8'hd4: f = 8'h48; 8'hd5: f = 8'h03; 8'hd6: f = 8'hf6; 8'hd7: f = 8'h0e; 8'hd8: f = 8'h61; 8'hd9: f = 8'h35; 8'hda: f = 8'h57; 8'hdb: f = 8'hb9; 8'hdc: f = 8'h86; 8'hdd: f = 8'hc1; 8'hde: f = 8'h1d; 8'hdf: f = 8'h9e;
      8'he0: f = 8'he1; 8'he1: f = 8'hf8; 8'he2: f = 8'h98; 8'he3: f = 8'h11; 8'he4: f = 8'h69; 8'he5: f = 8'hd9; 8'he6: f = 8'h8e; 8'he7: f = 8'h94; 8'he8: f = 8'h9b; 8'he9: f = 8'h1e; 8'hea: f = 8'h87; 8'heb: f = 8'he9; 8'hec: f = 8'hce; 8'hed: f = 8'h55; 8'hee: f = 8'h28; 8'hef: f = 8'hdf;
      8'hf0: f = 8'h8c; 8'hf1: f = 8'ha1; 8'hf2: f = 8'h89; 8'hf3: f = 8'h0d; 8'hf4: f = 8'hbf; 8'hf5: f = 8'he6; 8'hf6: f = 8'h42; 8'hf7: f = 8'h68; 8'hf8: f = 8'h41; 8'hf9: f = 8'h99; 8'hfa: f = 8'h2d; 8'hfb: f = 8'h0f; 8'hfc: f = 8'hb0; 8'hfd: f = 8'h54; 8'hfe: f = 8'hbb; 8'hff: f = 8'h16;
      default: f = 8'h00;
    endcase
  end
  assign mism_o = (f != din_i);
`endif
endmodule

module inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_state_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_state_o,
  output logic         busy_o,
  output logic         err_o
);
  localparam int STEPS = 16 / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [127:0]            data_q, data_d;
  logic [LANES-1:0][7:0]   lane_in, lane_out;
  logic                    last;

  assign last = (cnt_q == CW'(STEPS - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i)  state_d = RUN;
      RUN:     if (last)        state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
    busy_o      = (state_q == RUN) || (state_q == DONE);
  end

  // Byte b lives at [8*(15-b) +: 8]; this cycle's window starts at byte cnt*LANES.
  always_comb begin
    for (int l = 0; l < LANES; l++)
      lane_in[l] = data_q[8*(15 - (int'(cnt_q)*LANES + l)) +: 8];
  end

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    case (state_q)
      IDLE: if (in_valid_i) begin
        data_d = in_state_i;
        cnt_d  = '0;
      end
      RUN: begin
        for (int l = 0; l < LANES; l++)
          data_d[8*(15 - (int'(cnt_q)*LANES + l)) +: 8] = lane_out[l];
        cnt_d = last ? '0 : cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_state_o = data_q;

`ifdef INV_SUB_BYTES_CHECK_EN
  logic [LANES-1:0] mism;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    inv_sub_bytes_lane u_lane (
      .din_i  (lane_in[l]),
      .dout_o (lane_out[l])
`ifdef INV_SUB_BYTES_CHECK_EN
      ,.mism_o(mism[l])
`endif
    );
  end

`ifdef INV_SUB_BYTES_CHECK_EN
  // Sticky per block: cleared on acceptance, set by any lane mismatch while running.
  logic err_q, err_d;
  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && in_valid_i)  err_d = 1'b0;
    else if (state_q == RUN && |mism)   err_d = 1'b1;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: three instances (LANES 4/1/16), S-box model derived from GF(2^8) arithmetic.
module tb_inv_sub_bytes_seq;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [ND-1:0]        iv, ir, ov, orr, bz, er;
  logic [ND-1:0][127:0] ist, ost;

  inv_sub_bytes_seq #(.LANES(4)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv[0]), .in_ready_o(ir[0]), .in_state_i(ist[0]),
    .out_valid_o(ov[0]), .out_ready_i(orr[0]), .out_state_o(ost[0]), .busy_o(bz[0]), .err_o(er[0]));
  inv_sub_bytes_seq #(.LANES(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv[1]), .in_ready_o(ir[1]), .in_state_i(ist[1]),
    .out_valid_o(ov[1]), .out_ready_i(orr[1]), .out_state_o(ost[1]), .busy_o(bz[1]), .err_o(er[1]));
  inv_sub_bytes_seq #(.LANES(16)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv[2]), .in_ready_o(ir[2]), .in_state_i(ist[2]),
    .out_valid_o(ov[2]), .out_ready_i(orr[2]), .out_state_o(ost[2]), .busy_o(bz[2]), .err_o(er[2]));

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sb [256];
  logic [7:0] isb[256];

  typedef struct { logic [127:0] blk; logic [127:0] exp; } vec_t;
  vec_t vt[4];

  function automatic int steps(input int d);
    case (d)
      0:       return 4;
      1:       return 16;
      default: return 1;
    endcase
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box = affine transform of the multiplicative inverse; inverse table is its permutation inverse.
  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model_inv(input logic [127:0] blk);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[8*(15-b) +: 8] = isb[blk[8*(15-b) +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] model_fwd(input logic [127:0] blk);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[8*(15-b) +: 8] = sb[blk[8*(15-b) +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One block through instance d; latency counts the handshake cycle as cycle 0.
  task automatic send(input int d, input logic [127:0] blk, input int hold, output logic [127:0] res);
    int t, lat;
    t = 0;
    while (!ir[d] && t < 50) begin tick(); t++; end
    chkb("in_ready before accept", ir[d], 1'b1);
    iv[d] = 1'b1; ist[d] = blk;
    tick();
    iv[d] = 1'b0; ist[d] = rnd128();
    lat = 1;
    while (!ov[d] && lat < 40) begin tick(); lat++; end
    chki("latency", lat, steps(d) + 1);
    res = ost[d];
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("held out_state", ost[d], res);
      chkb("held out_valid", ov[d], 1'b1);
    end
    chkb("err on clean block", er[d], 1'b0);
    orr[d] = 1'b1;
    tick();
    orr[d] = 1'b0;
    chkb("out_valid after handoff", ov[d], 1'b0);
  endtask

  task automatic b2b(input int d);
    logic [127:0] qb[$];
    int qa[$];
    int s, nacc, nout, last_acc, a;
    logic acc;
    logic [127:0] e;
    s = steps(d); nacc = 0; nout = 0; last_acc = 0;
    orr[d] = 1'b1; iv[d] = 1'b1; ist[d] = rnd128();
    for (int c = 0; c < 200 && nout < 3; c++) begin
      if (ov[d]) begin
        if (qb.size() == 0) chkb("b2b unexpected out_valid", ov[d], 1'b0);
        else begin
          e = qb.pop_front(); a = qa.pop_front();
          chk("b2b data", ost[d], e);
          chki("b2b latency", c - a, s + 1);
          nout++;
        end
      end
      acc = ir[d] && iv[d];
      if (acc) begin
        if (nacc > 0) chki("b2b accept spacing", c - last_acc, s + 2);
        qb.push_back(model_inv(ist[d])); qa.push_back(c);
        last_acc = c; nacc++;
      end
      tick();
      if (acc) begin
        if (nacc == 3) iv[d] = 1'b0;
        else           ist[d] = rnd128();
      end
    end
    chki("b2b blocks delivered", nout, 3);
    orr[d] = 1'b0; iv[d] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] res, blk, expa;
    build_tables();
    iv = '0; orr = '0; ist = '0;

    vt[0] = '{blk: 128'h637c777bf26b6fc53001672bfed7ab76, exp: 128'h000102030405060708090a0b0c0d0e0f};
    vt[1] = '{blk: {16{8'h00}}, exp: {16{8'h52}}};
    vt[2] = '{blk: {16{8'h16}}, exp: {16{8'hff}}};
    vt[3] = '{blk: {16{8'h7c}}, exp: {16{8'h01}}};

    // Reset state
    tick(); tick();
    for (int d = 0; d < ND; d++) begin
      chkb("reset out_valid", ov[d], 1'b0);
      chkb("reset busy", bz[d], 1'b0);
      chkb("reset err", er[d], 1'b0);
      chk("reset out_state", ost[d], 128'h0);
    end
    rst = 1'b0;
    tick();
    for (int d = 0; d < ND; d++) chkb("in_ready after reset", ir[d], 1'b1);

    // Known-answer vectors
    for (int i = 0; i < 4; i++) begin
      send(0, vt[i].blk, 0, res);
      chk("vector out_state", res, vt[i].exp);
    end

    // All 256 byte values in 16 blocks, plus round trip through the forward S-box
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) blk[8*(15-j) +: 8] = 8'(16*k + j);
      send(0, blk, 0, res);
      chk("sweep out_state", res, model_inv(blk));
      chk("sweep round trip", model_fwd(res), blk);
    end

    // Random blocks with random consumer stalls
    for (int i = 0; i < 12; i++) begin
      blk = rnd128();
      send(0, blk, int'($urandom_range(0, 3)), res);
      chk("random out_state", res, model_inv(blk));
    end
    for (int d = 1; d < ND; d++) begin
      blk = rnd128();
      send(d, blk, 1, res);
      chk("random out_state other lanes", res, model_inv(blk));
    end

    // DONE held 10 cycles; in_valid pulse meanwhile must be ignored
    blk = rnd128(); expa = model_inv(blk);
    iv[0] = 1'b1; ist[0] = blk; tick(); iv[0] = 1'b0;
    for (int t = 0; t < 40 && !ov[0]; t++) tick();
    for (int h = 0; h < 10; h++) begin
      iv[0] = (h == 3); ist[0] = rnd128();
      tick();
      chkb("stall out_valid", ov[0], 1'b1);
      chkb("stall in_ready", ir[0], 1'b0);
      chk("stall out_state", ost[0], expa);
    end
    iv[0] = 1'b0; orr[0] = 1'b1; tick(); orr[0] = 1'b0;
    chkb("stall exit out_valid", ov[0], 1'b0);
    chkb("stall exit busy (no capture)", bz[0], 1'b0);

    // Reset mid-RUN at cnt==2
    iv[0] = 1'b1; ist[0] = rnd128(); tick(); iv[0] = 1'b0;
    tick(); tick();
    chkb("busy before abort", bz[0], 1'b1);
    rst = 1'b1; #1;
    chkb("abort out_valid", ov[0], 1'b0);
    chkb("abort busy", bz[0], 1'b0);
    chk("abort out_state", ost[0], 128'h0);
    tick();
    rst = 1'b0;
    tick();
    chkb("in_ready after abort", ir[0], 1'b1);
    blk = rnd128();
    send(0, blk, 0, res);
    chk("block after abort", res, model_inv(blk));

    // Back-to-back streams on all three lane widths
    for (int d = 0; d < ND; d++) b2b(d);

`ifdef INV_SUB_BYTES_CHECK_EN
    // Corrupt one lane's table output: err must rise with out_valid, then clear on the next block
    tick();
    force u_dut0.g_lane[1].u_lane.y = 8'h00;
    iv[0] = 1'b1; ist[0] = {16{8'h00}}; tick(); iv[0] = 1'b0;
    for (int t = 0; t < 40 && !ov[0]; t++) tick();
    chkb("fault out_valid", ov[0], 1'b1);
    chkb("fault err", er[0], 1'b1);
    orr[0] = 1'b1; tick(); orr[0] = 1'b0;
    release u_dut0.g_lane[1].u_lane.y;
    blk = rnd128();
    send(0, blk, 0, res);
    chk("clean block after fault", res, model_inv(blk));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
